// File: rtl/rggen_wishbone_arbiter.sv
// rggen_wishbone_arbiter
//   Round-robin arbiter that lets MASTERS pipelined Wishbone masters share one
//   slave, with at most one transaction outstanding on the slave side.
//
//   Parameters : ADDRESS_WIDTH (address bits), BUS_WIDTH (data bits, multiple
//                of 8), MASTERS (2..8 requesting masters).
//   Ports      : i_clk, i_rst_n (async, active low)
//                i_m_wb_* / o_m_wb_*  per-master buses, master m at slice m
//                o_s_wb_* / i_s_wb_*  shared slave-side bus
//   Build macro: RGGEN_WISHBONE_ARBITER_LOCK_EN keeps the grant across
//                back-to-back strobes while the granted master holds cyc.
module rggen_wishbone_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int MASTERS       = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [MASTERS-1:0]                i_m_wb_cyc,
  input  logic [MASTERS-1:0]                i_m_wb_stb,
  input  logic [MASTERS-1:0]                i_m_wb_we,
  input  logic [ADDRESS_WIDTH*MASTERS-1:0]  i_m_wb_adr,
  input  logic [BUS_WIDTH*MASTERS-1:0]      i_m_wb_dat,
  input  logic [BUS_WIDTH/8*MASTERS-1:0]    i_m_wb_sel,
  output logic [MASTERS-1:0]                o_m_wb_stall,
  output logic [MASTERS-1:0]                o_m_wb_ack,
  output logic [MASTERS-1:0]                o_m_wb_err,
  output logic [MASTERS-1:0]                o_m_wb_rty,
  output logic [BUS_WIDTH*MASTERS-1:0]      o_m_wb_dat,
  output logic                              o_s_wb_cyc,
  output logic                              o_s_wb_stb,
  output logic                              o_s_wb_we,
  output logic [ADDRESS_WIDTH-1:0]          o_s_wb_adr,
  output logic [BUS_WIDTH-1:0]              o_s_wb_dat,
  output logic [BUS_WIDTH/8-1:0]            o_s_wb_sel,
  input  logic                              i_s_wb_stall,
  input  logic                              i_s_wb_ack,
  input  logic                              i_s_wb_err,
  input  logic                              i_s_wb_rty,
  input  logic [BUS_WIDTH-1:0]              i_s_wb_dat
);

  localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SW = BUS_WIDTH / 8;

`ifdef RGGEN_WISHBONE_ARBITER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT_RESPONSE
  } state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last;
  logic              locked;
  logic [GW-1:0]     winner;
  logic              any_req;
  logic              cyc_g;
  logic              stb_g;
  logic              term;
  logic [MASTERS-1:0] req;

  assign req  = i_m_wb_cyc & i_m_wb_stb;
  assign term = i_s_wb_ack | i_s_wb_err | i_s_wb_rty;

  // Round-robin search: candidates are visited in order last+1, last+2, ...
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned i = 1; i <= MASTERS; i++) begin
      for (int unsigned m = 0; m < MASTERS; m++) begin
        if (!any_req && req[m] && (((32'(last) + i) % MASTERS) == m)) begin
          any_req = 1'b1;
          winner  = GW'(m);
        end
      end
    end
  end

  // Granted-master mux onto the slave bus.
  always_comb begin
    cyc_g      = 1'b0;
    stb_g      = 1'b0;
    o_s_wb_we  = 1'b0;
    o_s_wb_adr = '0;
    o_s_wb_dat = '0;
    o_s_wb_sel = '0;
    for (int unsigned m = 0; m < MASTERS; m++) begin
      if (grant == GW'(m)) begin
        cyc_g      = i_m_wb_cyc[m];
        stb_g      = i_m_wb_stb[m];
        o_s_wb_we  = i_m_wb_we[m];
        o_s_wb_adr = i_m_wb_adr[m*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        o_s_wb_dat = i_m_wb_dat[m*BUS_WIDTH +: BUS_WIDTH];
        o_s_wb_sel = i_m_wb_sel[m*SW +: SW];
      end
    end
  end

  // A locked grant parks in IDLE with cyc still asserted to the slave.
  assign o_s_wb_cyc = (state != IDLE) || locked;
  assign o_s_wb_stb = (state == ACCESS);
  assign o_m_wb_dat = {MASTERS{i_s_wb_dat}};

  // Terminations are only forwarded while the owner still holds cyc.
  always_comb begin
    o_m_wb_stall = '1;
    o_m_wb_ack   = '0;
    o_m_wb_err   = '0;
    o_m_wb_rty   = '0;
    for (int unsigned m = 0; m < MASTERS; m++) begin
      if (grant == GW'(m)) begin
        if (state == ACCESS) begin
          o_m_wb_stall[m] = i_s_wb_stall;
        end
        if ((state == WAIT_RESPONSE) && i_m_wb_cyc[m]) begin
          o_m_wb_ack[m] = i_s_wb_ack;
          o_m_wb_err[m] = i_s_wb_err;
          o_m_wb_rty[m] = i_s_wb_rty;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      last   <= GW'(MASTERS - 1);
      locked <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (locked) begin
            if (!cyc_g) begin
              locked <= 1'b0;
              last   <= grant;
            end else if (stb_g) begin
              state <= ACCESS;
            end
          end else if (any_req) begin
            grant <= winner;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!cyc_g) begin
            state  <= IDLE;
            locked <= 1'b0;
            last   <= grant;
          end else if (!i_s_wb_stall) begin
            state <= WAIT_RESPONSE;
          end
        end
        WAIT_RESPONSE: begin
          if (!cyc_g) begin
            state  <= IDLE;
            locked <= 1'b0;
            last   <= grant;
          end else if (term) begin
            state <= IDLE;
            if (LOCK_EN) begin
              locked <= 1'b1;
            end else begin
              last <= grant;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_wishbone_arbiter.sv
module tb_rggen_wishbone_arbiter;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int M  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [M-1:0]      m_cyc = '0, m_stb = '0, m_we = '0;
  logic [AW*M-1:0]   m_adr = '0;
  logic [BW*M-1:0]   m_dat = '0;
  logic [BW/8*M-1:0] m_sel = '0;
  logic [M-1:0]      m_stall, m_ack, m_err, m_rty;
  logic [BW*M-1:0]   m_rdat;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [BW-1:0]     s_wdat;
  logic [BW/8-1:0]   s_sel;
  logic              s_stall = 1'b0, s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
  logic [BW-1:0]     s_rdat = '0;

  rggen_wishbone_arbiter #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .MASTERS       (M)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_m_wb_cyc   (m_cyc),
    .i_m_wb_stb   (m_stb),
    .i_m_wb_we    (m_we),
    .i_m_wb_adr   (m_adr),
    .i_m_wb_dat   (m_dat),
    .i_m_wb_sel   (m_sel),
    .o_m_wb_stall (m_stall),
    .o_m_wb_ack   (m_ack),
    .o_m_wb_err   (m_err),
    .o_m_wb_rty   (m_rty),
    .o_m_wb_dat   (m_rdat),
    .o_s_wb_cyc   (s_cyc),
    .o_s_wb_stb   (s_stb),
    .o_s_wb_we    (s_we),
    .o_s_wb_adr   (s_adr),
    .o_s_wb_dat   (s_wdat),
    .o_s_wb_sel   (s_sel),
    .i_s_wb_stall (s_stall),
    .i_s_wb_ack   (s_ack),
    .i_s_wb_err   (s_err),
    .i_s_wb_rty   (s_rty),
    .i_s_wb_dat   (s_rdat)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", name, idx, act, exp, $time);
  endtask

  // ---------------- slave responder ----------------
  int          stall_cfg = 0, resp_delay = 0, resp_kind = 0;
  logic [31:0] rdata_cfg = '0;
  int          stall_left = 0, pend = 0;
  bit          in_req = 1'b0;

  always begin
    @(posedge clk);
    #1;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        case (resp_kind)
          0:       s_ack = 1'b1;
          1:       s_err = 1'b1;
          default: s_rty = 1'b1;
        endcase
        s_rdat = rdata_cfg;
      end
    end
    if (s_stb) begin
      if (!in_req) begin
        in_req = 1'b1;
        stall_left = stall_cfg;
      end
      if (stall_left > 0) begin
        s_stall = 1'b1;
        stall_left--;
      end else begin
        s_stall = 1'b0;
        in_req = 1'b0;
        pend = 1 + resp_delay;
      end
    end else begin
      s_stall = 1'b0;
      in_req = 1'b0;
    end
  end

  // ---------------- behavioural model ----------------
  // Transaction view: an owner holds the slave from grant until it is
  // terminated or abandons cyc; its strobe is pending until accepted.
  bit mo_have = 1'b0, mo_acc = 1'b0;
  int mo_owner = 0, mo_ptr = M - 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mo_have = 1'b0; mo_acc = 1'b0; mo_owner = 0; mo_ptr = M - 1;
    end else if (!mo_have) begin
      for (int k = 1; k <= M; k++) begin
        if (!mo_have && m_cyc[(mo_ptr + k) % M] && m_stb[(mo_ptr + k) % M]) begin
          mo_have = 1'b1; mo_acc = 1'b0; mo_owner = (mo_ptr + k) % M;
        end
      end
    end else if (!m_cyc[mo_owner]) begin
      mo_have = 1'b0; mo_ptr = mo_owner;
    end else if (!mo_acc) begin
      if (!s_stall) mo_acc = 1'b1;
    end else if (s_ack || s_err || s_rty) begin
      mo_have = 1'b0; mo_ptr = mo_owner;
    end
  end

  int   ack_cnt[M], err_cnt[M];
  int   gq[$];
  logic prev_stb = 1'b0;
  logic exp_stb, fwd, exp_stall;

  always @(negedge clk) begin
    if (check_en) begin
      exp_stb = mo_have && !mo_acc;
      chk("s_cyc", 0, s_cyc, mo_have);
      chk("s_stb", 0, s_stb, exp_stb);
      if (exp_stb) begin
        chk("s_adr", mo_owner, s_adr, m_adr[mo_owner*AW +: AW]);
        chk("s_wdat", mo_owner, s_wdat, m_dat[mo_owner*BW +: BW]);
        chk("s_sel", mo_owner, s_sel, m_sel[mo_owner*4 +: 4]);
        chk("s_we", mo_owner, s_we, m_we[mo_owner]);
      end
      for (int m = 0; m < M; m++) begin
        exp_stall = (exp_stb && m == mo_owner) ? s_stall : 1'b1;
        fwd = mo_have && mo_acc && (m == mo_owner) && m_cyc[m];
        chk("m_stall", m, m_stall[m], exp_stall);
        chk("m_ack", m, m_ack[m], fwd && s_ack);
        chk("m_err", m, m_err[m], fwd && s_err);
        chk("m_rty", m, m_rty[m], fwd && s_rty);
        if (fwd && (s_ack || s_err || s_rty)) chk("m_rdat", m, m_rdat[m*BW +: BW], s_rdat);
        ack_cnt[m] += int'(m_ack[m]);
        err_cnt[m] += int'(m_err[m]);
      end
      if (s_stb && !prev_stb) gq.push_back(int'(s_adr[7:4]) - 1);
      prev_stb = s_stb;
    end
  end

  // ---------------- master driver ----------------
  task automatic txn(input int m, input bit we, input logic [7:0] adr, input logic [31:0] wd,
                     output int kind, output logic [31:0] rd, output int stall_cycles);
    bit done;
    int t;
    kind = -1; rd = '0; stall_cycles = 0;
    m_we[m] = we; m_adr[m*AW +: AW] = adr; m_dat[m*BW +: BW] = wd; m_sel[m*4 +: 4] = 4'hF;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
    done = 1'b0; t = 0;
    while (!done && t < 200) begin
      @(negedge clk); t++;
      if (s_stb && s_adr == adr && !m_stall[m]) done = 1'b1;
      else if (s_stb && s_adr == adr) stall_cycles++;
    end
    chk("accepted", m, done, 1);
    @(posedge clk); #1;
    m_stb[m] = 1'b0;
    done = 1'b0; t = 0;
    while (!done && t < 50) begin
      @(negedge clk); t++;
      if (m_ack[m] || m_err[m] || m_rty[m]) begin
        done = 1'b1;
        kind = m_ack[m] ? 0 : (m_err[m] ? 1 : 2);
        rd = m_rdat[m*BW +: BW];
      end
    end
    chk("terminated", m, done, 1);
    @(posedge clk); #1;
    m_cyc[m] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int          k0, k1, s0, s1, a0, e0;
  logic [31:0] r0, r1;
  int          exp_q[$];

  initial begin
    ack_cnt = '{default: 0};
    err_cnt = '{default: 0};
    step();
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_s_cyc", 0, s_cyc, 0);
    chk("rst_stall", 0, m_stall, 2'b11);
    chk("rst_ack", 0, m_ack, 0);
    step();
    rst_n = 1'b1;
    step();

    // Single write from master 0: one cycle to strobe, ack one cycle after acceptance.
    a0 = ack_cnt[0];
    m_we[0] = 1'b1; m_adr[7:0] = 8'h10; m_dat[31:0] = 32'hA5A5A5A5; m_sel[3:0] = 4'hF;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(negedge clk);
    chk("t1_stb_idle", 0, s_stb, 0);
    step();
    @(negedge clk);
    chk("t1_stb", 0, s_stb, 1);
    chk("t1_adr", 0, s_adr, 8'h10);
    chk("t1_wdat", 0, s_wdat, 32'hA5A5A5A5);
    chk("t1_we", 0, s_we, 1);
    chk("t1_stall1", 1, m_stall[1], 1);
    step();
    m_stb[0] = 1'b0;
    @(negedge clk);
    chk("t1_ack", 0, m_ack[0], 1);
    chk("t1_stall1w", 1, m_stall[1], 1);
    step();
    m_cyc[0] = 1'b0;
    step(); step();
    chk("t1_ack_once", 0, ack_cnt[0] - a0, 1);

    // Master 1 read returns slave data.
    rdata_cfg = 32'h12345678;
    txn(1, 1'b0, 8'h20, 32'h0, k1, r1, s1);
    chk("rd_kind", 1, k1, 0);
    chk("rd_data", 1, r1, 32'h12345678);
    step();

    // Both masters request continuously: grants alternate.
    gq.delete();
    fork
      begin repeat (2) txn(0, 1'b1, 8'h10, 32'h11111111, k0, r0, s0); end
      begin repeat (2) txn(1, 1'b1, 8'h20, 32'h22222222, k1, r1, s1); end
    join
    step();
    exp_q = '{0, 1, 0, 1};
    chk("rr_len", 0, gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_order", i, gq[i], exp_q[i]);

    // Master 0 two back-to-back accesses vs master 1: no lock, order 0,1,0.
    gq.delete();
    fork
      begin repeat (2) txn(0, 1'b1, 8'h10, 32'h33333333, k0, r0, s0); end
      begin txn(1, 1'b1, 8'h20, 32'h44444444, k1, r1, s1); end
    join
    step();
    exp_q = '{0, 1, 0};
    chk("lock_len", 0, gq.size(), 3);
    for (int i = 0; i < 3 && i < gq.size(); i++) chk("lock_order", i, gq[i], exp_q[i]);

    // Slave stalls 3 cycles then errors.
    stall_cfg = 3; resp_kind = 1;
    a0 = ack_cnt[0]; e0 = err_cnt[0];
    txn(0, 1'b1, 8'h14, 32'hDEADBEEF, k0, r0, s0);
    step();
    chk("err_kind", 0, k0, 1);
    chk("err_stalls", 0, s0, 3);
    chk("err_once", 0, err_cnt[0] - e0, 1);
    chk("err_no_ack", 0, ack_cnt[0] - a0, 0);
    stall_cfg = 0; resp_kind = 0;

    // Master 0 abandons in WAIT_RESPONSE; late ack lands in IDLE and is dropped.
    resp_delay = 1;
    gq.delete();
    a0 = ack_cnt[0];
    m_we[0] = 1'b1; m_adr[7:0] = 8'h18; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    step();
    m_stb[0] = 1'b0; m_cyc[0] = 1'b0;
    txn(1, 1'b0, 8'h28, 32'h0, k1, r1, s1);
    step();
    chk("abort_no_ack", 0, ack_cnt[0] - a0, 0);
    chk("abort_next", 0, gq.size(), 2);
    if (gq.size() == 2) chk("abort_next_grant", 0, gq[1], 1);
    chk("abort_m1_kind", 1, k1, 0);
    resp_delay = 0;
    step();

    // Reset while the response is on the bus: nothing forwarded.
    m_we[0] = 1'b1; m_adr[7:0] = 8'h1C; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    step();
    m_stb[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_sack", 0, s_ack, 1);
    chk("rst_mid_ack", 0, m_ack[0], 0);
    chk("rst_mid_cyc", 0, s_cyc, 0);
    chk("rst_mid_stall", 0, m_stall, 2'b11);
    step();
    rst_n = 1'b1;
    m_cyc[0] = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rggen_wishbone_arbiter.md
RGGEN_WISHBONE_ARBITER -- requirements
Module: rggen_wishbone_arbiter

Interface
REQ-001 Parameters SHALL be: ADDRESS_WIDTH, default 8, address bits; BUS_WIDTH, default 32, data bits (multiple of 8); MASTERS, default 2, number of requesting Wishbone masters (2..8).
REQ-002 Ports SHALL be as follows; arrays are packed vectors with master m at slice m:
- i_clk  in  1  clock; single clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_m_wb_cyc / i_m_wb_stb / i_m_wb_we  in  MASTERS each  per-master cycle, strobe, write.
- i_m_wb_adr  in  ADDRESS_WIDTH*MASTERS  per-master address.
- i_m_wb_dat  in  BUS_WIDTH*MASTERS  per-master write data.
- i_m_wb_sel  in  BUS_WIDTH/8*MASTERS  per-master byte select.
- o_m_wb_stall / o_m_wb_ack / o_m_wb_err / o_m_wb_rty  out  MASTERS each  per-master pipelined stall and terminations.
- o_m_wb_dat  out  BUS_WIDTH*MASTERS  per-master read data.
- o_s_wb_cyc / o_s_wb_stb / o_s_wb_we  out  1 each  shared slave-side cycle, strobe, write.
- o_s_wb_adr  out  ADDRESS_WIDTH  slave address; o_s_wb_dat  out  BUS_WIDTH  write data; o_s_wb_sel  out  BUS_WIDTH/8  byte select.
- i_s_wb_stall / i_s_wb_ack / i_s_wb_err / i_s_wb_rty  in  1 each  slave stall and terminations.
- i_s_wb_dat  in  BUS_WIDTH  slave read data.

Function
REQ-003 Request of master m SHALL be i_m_wb_cyc[m] && i_m_wb_stb[m]; at most one transaction outstanding on the slave side.
REQ-004 FSM states SHALL be IDLE, ACCESS, WAIT_RESPONSE.
REQ-005 IDLE: if any request, register grant index (round-robin winner) and go to ACCESS next cycle; otherwise stay; o_s_wb_cyc=o_s_wb_stb=0.
REQ-006 Round-robin: search starts at (last granted + 1) mod MASTERS; after reset master 0 has highest priority.
REQ-007 ACCESS: o_s_wb_cyc=o_s_wb_stb=1; adr/we/dat/sel combinationally muxed from granted master; o_m_wb_stall[grant]=i_s_wb_stall; on !i_s_wb_stall go to WAIT_RESPONSE.
REQ-008 WAIT_RESPONSE: o_s_wb_cyc=1, o_s_wb_stb=0; on i_s_wb_ack, err or rty forward that bit to o_m_wb_*[grant] in the same cycle, o_m_wb_dat[grant]=i_s_wb_dat, update last-granted pointer, go to IDLE.
REQ-009 o_m_wb_stall[m] SHALL be 1 for every master except the granted master in ACCESS; termination outputs of non-granted masters SHALL be 0.
REQ-010 If the granted master deasserts i_m_wb_cyc in ACCESS or WAIT_RESPONSE, the arbiter SHALL drop o_s_wb_cyc/stb in the next cycle, discard any later response, return to IDLE and advance the pointer.
REQ-011 Slave termination arriving in IDLE SHALL be ignored.
REQ-012 Arbitration latency SHALL be 1 cycle from request to o_s_wb_stb; minimum 3 cycles per transaction for an ack one cycle after acceptance.

Reset
REQ-013 On i_rst_n low, asynchronously: state IDLE, pointer = MASTERS-1 (so master 0 wins first), grant 0; o_s_wb_cyc/stb=0, all o_m_wb_ack/err/rty=0, all o_m_wb_stall=1.
REQ-014 Reset mid-transaction SHALL abort without forwarding any termination.

Configuration
REQ-015 Macro RGGEN_WISHBONE_ARBITER_LOCK_EN: when defined, after a termination the grant SHALL be kept while the granted master holds i_m_wb_cyc high (next stb goes directly to ACCESS, o_s_wb_cyc stays 1, pointer not advanced); lock releases when cyc drops. When undefined, every termination returns to IDLE and re-arbitrates, with o_s_wb_cyc low for at least one cycle.

Verification
REQ-016 Reset then master 0 write adr 0x10 dat 0xA5A5A5A5, slave no stall, ack 1 cycle later -> o_s_wb_stb high 1 cycle after request, o_m_wb_ack[0] pulses once, master 1 sees stall=1 throughout.
REQ-017 Masters 0 and 1 request simultaneously, repeatedly -> grants alternate 0,1,0,1.
REQ-018 Slave stalls 3 cycles then err -> o_m_wb_stall[grant]=1 for 3 cycles, o_m_wb_err[grant] pulses, ack stays 0.
REQ-019 Master 1 read, slave returns 0x12345678 with ack -> o_m_wb_dat[1]=0x12345678 when o_m_wb_ack[1]=1.
REQ-020 Granted master drops cyc in WAIT_RESPONSE, late ack -> no termination forwarded, other master granted next.
REQ-021 With LOCK_EN, master 0 issues 2 stb under one cyc while master 1 requests -> both master-0 accesses complete before master 1 is granted; without LOCK_EN, order is 0,1,0.
